// File: rtl/rr_priority_encoder.sv
// Registered, handshaked priority encoder with run-time selectable
// fixed-priority or round-robin selection. One output slot holds the
// current grant until the consumer accepts it; a new winner loads on the
// same edge as the handshake, giving one grant per cycle.
module rr_priority_encoder #(
   parameter int unsigned NUM_REQ = 16,
   parameter int unsigned IW      = $clog2(NUM_REQ)
) (
   input  logic               clk_i,
   input  logic               arst_ni,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               rr_en_i,
   output logic               gnt_valid_o,
   input  logic               gnt_ready_i,
   output logic [IW-1:0]      gnt_index_o,
   output logic [NUM_REQ-1:0] gnt_onehot_o
);

   typedef enum logic {
      EMPTY = 1'b0,
      HELD  = 1'b1
   } state_e;

   localparam logic [IW:0]   NUM_REQ_W = (IW+1)'(NUM_REQ);
   localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);

   state_e             state_q, state_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [IW-1:0]      ptr_q, ptr_d;
   logic [NUM_REQ-1:0] oh_q, oh_d;

   logic               handshake;
   logic               load;
   logic [IW-1:0]      idx_succ;
   logic [IW-1:0]      start;
   logic [IW:0]        cand;
   logic               found;
   logic [IW-1:0]      win_idx;
   logic [NUM_REQ-1:0] win_oh;

   // Handshake, load qualifier and search start point.
   // idx_succ wraps explicitly so non-power-of-two sizes never reach NUM_REQ.
   always_comb begin
      handshake = (state_q == HELD) && gnt_ready_i;
      load      = (state_q == EMPTY) || handshake;
      idx_succ  = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
      if (!rr_en_i) begin
         start = '0;
      end else if (handshake) begin
         start = idx_succ;
      end else begin
         start = ptr_q;
      end
   end

   // Circular scan from start; the first set request wins.
   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      cand    = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = {1'b0, start} + (IW+1)'(i);
         if (cand >= NUM_REQ_W) begin
            cand = cand - NUM_REQ_W;
         end
         if (!found && req_i[cand[IW-1:0]]) begin
            found   = 1'b1;
            win_idx = cand[IW-1:0];
         end
      end
      win_oh = found ? (NUM_REQ'(1) << win_idx) : '0;
   end

   // State and datapath registers.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_q <= EMPTY;
         idx_q   <= '0;
         oh_q    <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         oh_q    <= oh_d;
         ptr_q   <= ptr_d;
      end
   end

   // Next-state: reload on EMPTY or handshake, otherwise the grant is locked.
   // An empty load keeps the stale index but clears the one-hot.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      oh_d    = oh_q;
      ptr_d   = handshake ? idx_succ : ptr_q;
      if (load) begin
         if (found) begin
            state_d = HELD;
            idx_d   = win_idx;
            oh_d    = win_oh;
         end else begin
            state_d = EMPTY;
            oh_d    = '0;
         end
      end
   end

   // Outputs come straight from registers.
   always_comb begin
      gnt_valid_o  = (state_q == HELD);
      gnt_index_o  = idx_q;
      gnt_onehot_o = oh_q;
   end

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Scoreboard bench for rr_priority_encoder: a 16-wide and a 5-wide
// instance; expected grant indices are queued by the stimulus and popped
// by per-instance monitors on every handshake.
module tb_rr_priority_encoder;

   logic        clk;
   logic        arst_n;
   logic [15:0] req;
   logic        rr;
   logic        ready;
   logic        valid;
   logic [3:0]  idx;
   logic [15:0] oh;

   logic [4:0]  req5;
   logic        rr5;
   logic        ready5;
   logic        valid5;
   logic [2:0]  idx5;
   logic [4:0]  oh5;

   int total = 0;
   int bad   = 0;
   int q16[$];
   int q5[$];

   rr_priority_encoder #(.NUM_REQ(16)) dut (
      .clk_i        (clk),
      .arst_ni      (arst_n),
      .req_i        (req),
      .rr_en_i      (rr),
      .gnt_valid_o  (valid),
      .gnt_ready_i  (ready),
      .gnt_index_o  (idx),
      .gnt_onehot_o (oh)
   );

   rr_priority_encoder #(.NUM_REQ(5)) dut5 (
      .clk_i        (clk),
      .arst_ni      (arst_n),
      .req_i        (req5),
      .rr_en_i      (rr5),
      .gnt_valid_o  (valid5),
      .gnt_ready_i  (ready5),
      .gnt_index_o  (idx5),
      .gnt_onehot_o (oh5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor for the 16-wide instance: compare on every handshake.
   always @(negedge clk) begin
      if (arst_n && valid && ready) begin
         if (q16.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_grant16: got idx %0d expected none at %0t", idx, $time);
         end else begin
            int e;
            logic [15:0] eoh;
            e   = q16.pop_front();
            eoh = 16'(1) << e;
            chk("grant16_idx", 32'(idx), 32'(e));
            chk("grant16_oh", 32'(oh), 32'(eoh));
         end
      end
   end

   // Monitor for the 5-wide instance.
   always @(negedge clk) begin
      if (arst_n && valid5 && ready5) begin
         if (q5.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_grant5: got idx %0d expected none at %0t", idx5, $time);
         end else begin
            int e;
            logic [4:0] eoh;
            e   = q5.pop_front();
            eoh = 5'(1) << e;
            chk("grant5_idx", 32'(idx5), 32'(e));
            chk("grant5_oh", 32'(oh5), 32'(eoh));
         end
      end
   end

   initial begin
      // Reset and empty
      arst_n = 1'b0;
      req    = 16'hFFFF;
      rr     = 1'b0;
      ready  = 1'b0;
      req5   = '0;
      rr5    = 1'b1;
      ready5 = 1'b0;
      #12;
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_idx", 32'(idx), 32'd0);
      chk("rst_oh", 32'(oh), 32'd0);
      req = 16'h0000;
      #1 arst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("empty_valid", 32'(valid), 32'd0);
         chk("empty_idx", 32'(idx), 32'd0);
         chk("empty_oh", 32'(oh), 32'd0);
      end

      // Fixed priority, stalled consumer
      tick();
      rr    = 1'b0;
      req   = 16'h00A0;
      ready = 1'b0;
      tick();
      repeat (3) begin
         @(negedge clk);
         chk("stall_valid", 32'(valid), 32'd1);
         chk("stall_idx", 32'(idx), 32'd5);
         chk("stall_oh", 32'(oh), 32'h0020);
      end
      tick();
      q16.push_back(5);
      req   = 16'h0001;
      ready = 1'b1;
      tick();
      q16.push_back(0);
      req = 16'h0000;
      tick();
      ready = 1'b0;
      @(negedge clk);
      chk("fixed_end_valid", 32'(valid), 32'd0);
      chk("fixed_end_oh", 32'(oh), 32'd0);
      #1 arst_n = 1'b0;
      #2 arst_n = 1'b1;

      // Round-robin fairness, one grant per cycle
      tick();
      rr    = 1'b1;
      req   = 16'h8421;
      ready = 1'b1;
      for (int k = 0; k < 8; k++) q16.push_back((k % 4) * 5);
      repeat (8) begin
         @(posedge clk);
         @(negedge clk);
         chk("rr_valid", 32'(valid), 32'd1);
      end
      req = 16'h0000;
      tick();
      ready = 1'b0;
      @(negedge clk);
      chk("rr_end_valid", 32'(valid), 32'd0);

      // Grant lock
      tick();
      req = 16'h0008;
      tick();
      req = 16'h0000;
      repeat (4) begin
         @(negedge clk);
         chk("lock_valid", 32'(valid), 32'd1);
         chk("lock_idx", 32'(idx), 32'd3);
         tick();
      end
      q16.push_back(3);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      @(negedge clk);
      chk("lock_rel_valid", 32'(valid), 32'd0);
      chk("lock_rel_oh", 32'(oh), 32'd0);
      chk("lock_rel_idx_kept", 32'(idx), 32'd3);
      tick();
      req = 16'hFFFF;
      tick();
      @(negedge clk);
      chk("ptr4_idx", 32'(idx), 32'd4);
      chk("ptr4_oh", 32'(oh), 32'h0010);
      tick();
      q16.push_back(4);
      ready = 1'b1;
      req   = 16'h0000;
      tick();
      ready = 1'b0;

      // Mid-transaction reset, then fixed-mode grant
      req = 16'h0080;
      tick();
      @(negedge clk);
      chk("pre_rst_idx", 32'(idx), 32'd7);
      chk("pre_rst_valid", 32'(valid), 32'd1);
      #2 arst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(valid), 32'd0);
      chk("async_rst_oh", 32'(oh), 32'd0);
      @(posedge clk);
      #2;
      arst_n = 1'b1;
      rr     = 1'b0;
      req    = 16'h0180;
      tick();
      @(negedge clk);
      chk("post_rst_valid", 32'(valid), 32'd1);
      chk("post_rst_idx", 32'(idx), 32'd7);
      chk("post_rst_oh", 32'(oh), 32'h0080);
      tick();
      q16.push_back(7);
      ready = 1'b1;
      req   = 16'h0000;
      tick();
      ready = 1'b0;

      // Pointer cleared by reset: ptr=8 grant, reset, then search from 0
      rr  = 1'b1;
      req = 16'h0180;
      tick();
      @(negedge clk);
      chk("ptr8_idx", 32'(idx), 32'd8);
      #2 arst_n = 1'b0;
      #1;
      chk("rst2_valid", 32'(valid), 32'd0);
      @(posedge clk);
      #2;
      arst_n = 1'b1;
      req    = 16'hFFFF;
      tick();
      @(negedge clk);
      chk("ptr_cleared_idx", 32'(idx), 32'd0);
      tick();
      q16.push_back(0);
      ready = 1'b1;
      req   = 16'h0000;
      tick();
      ready = 1'b0;

      // Non-power-of-two wrap on the 5-wide instance
      tick();
      rr5    = 1'b1;
      req5   = 5'b10001;
      ready5 = 1'b1;
      for (int k = 0; k < 6; k++) q5.push_back((k % 2) * 4);
      repeat (6) begin
         @(posedge clk);
         @(negedge clk);
         chk("wrap5_valid", 32'(valid5), 32'd1);
      end
      req5 = '0;
      tick();
      ready5 = 1'b0;

      repeat (3) tick();
      chk("q16_drained", 32'(q16.size()), 32'd0);
      chk("q5_drained", 32'(q5.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Safety bound so the run always ends.
   initial begin
      #100000;
      $display("FAIL timeout: got no completion expected finish at %0t", $time);
      $fatal(1);
   end

endmodule

// File: doc/rr_priority_encoder.md
# rr_priority_encoder

Registered, handshaked priority encoder that picks one active request line per transaction and presents its binary index and one-hot grant to a downstream consumer. Selection is either fixed-priority (lowest index wins) or round-robin, chosen at run time, so one block serves both static-priority decode and fair multi-source arbitration, such as writeback ports, issue slots or reservation-station wakeup. Each grant is held stable until the consumer accepts it. Throughput is one grant per cycle.

## Interface
- NUM_REQ, 16, number of request lines; legal range is 2 or more, and non-power-of-two values are allowed
- IW, $clog2(NUM_REQ), index width (derived; do not override)
- clk_i  input  1  clock; all state updates on the rising edge
- arst_ni  input  1  asynchronous, active-low reset
- req_i  input  NUM_REQ  request vector; bit k is requester k
- rr_en_i  input  1  0 selects fixed priority, 1 selects round-robin
- gnt_valid_o  output  1  a grant is held in the output register
- gnt_ready_i  input  1  consumer accepts the held grant
- gnt_index_o  output  IW  binary index of the granted requester
- gnt_onehot_o  output  NUM_REQ  one-hot form of gnt_index_o; all zero when gnt_valid_o=0

## Operation
- Reset values while arst_ni=0: gnt_valid_o=0, gnt_index_o=0, gnt_onehot_o=0, round-robin pointer ptr=0.
- State is one output register slot: EMPTY (gnt_valid_o=0) or HELD (gnt_valid_o=1).
- The slot loads when it is EMPTY, or when it is HELD and gnt_ready_i=1 in that cycle (handshake).
- Search start s:
  - s=0 when rr_en_i=0.
  - When rr_en_i=1: s=(gnt_index_o+1) mod NUM_REQ on a handshake cycle; otherwise s=ptr.
- Winner: the first set bit of req_i scanning s, s+1, … NUM_REQ-1, 0, … s-1. Wrap is mod NUM_REQ and never reaches an index of NUM_REQ or higher.
- Load with a winner: the slot becomes HELD with the winner's index and one-hot value.
- Load with req_i all zero: the slot becomes EMPTY and gnt_onehot_o=0. gnt_index_o keeps its last value; consumers must ignore it while gnt_valid_o=0.
- HELD with no handshake: index, one-hot and valid are frozen, even if req_i changes or the granted request drops. The grant is locked.
- Pointer update:
  - On each handshake, ptr <= (gnt_index_o+1) mod NUM_REQ, regardless of rr_en_i.
  - Otherwise ptr holds.
- Mode changes on rr_en_i take effect at the next load only; they never disturb a HELD grant.
- gnt_ready_i while EMPTY has no effect; it is not a handshake.
- The block never drops a grant or produces two grants in one cycle.
- The block does not check the requester's own req_i after the grant. Requesters must keep req_i asserted until they see their grant accepted if they need service again.

## Timing
- Request-to-grant latency is one cycle. req_i sampled at edge N appears on the grant outputs after edge N, provided the slot loads at N.
- The handshake and the next load happen on the same edge, so back-to-back grants on consecutive cycles are possible when gnt_ready_i is held at 1.
- All outputs are registered. There is no combinational path from req_i, rr_en_i or gnt_ready_i to any output.
- Asynchronous reset mid-transaction discards the held grant immediately, with no handshake, and clears ptr to 0.
- Reset deassertion is synchronised externally. The first load happens at the first rising edge with arst_ni=1.

## Test plan
- Reset and empty:
  - Stimulus: assert arst_ni=0 with req_i=16'hFFFF, then release it with req_i=0 for 5 cycles.
  - Required response: all outputs stay 0 throughout.
- Fixed priority with a stalled consumer:
  - Stimulus: rr_en_i=0, req_i=16'h00A0, gnt_ready_i=0 for 3 cycles, then change req_i to 16'h0001.
  - Required response: index 5, onehot 16'h0020, held for all 3 cycles. After ready=1, the next grant is index 0.
- Round-robin fairness:
  - Stimulus: rr_en_i=1, req_i=16'h8421, gnt_ready_i=1 constantly.
  - Required response: the index sequence is 0, 5, 10, 15, 0, 5, …, one grant per cycle, with gnt_valid_o continuously 1.
- Wrap and non-power-of-two:
  - Stimulus: NUM_REQ=5, rr_en_i=1, req_i=5'b10001, ready=1.
  - Required response: grants alternate 0, 4, 0, 4. The index never reaches 5, 6 or 7.
- Grant lock:
  - Stimulus: rr_en_i=1. Grant index 3 is held, then req_i drops to 0 with ready=0 for 4 cycles.
  - Required response: valid=1 and index 3 persist. On ready=1, the slot goes EMPTY and ptr becomes 4.
- Mid-transaction reset and mode switch:
  - Stimulus: while index 7 is HELD, assert arst_ni=0 for one cycle.
  - Required response: valid drops asynchronously and ptr becomes 0. Then, with rr_en_i toggled to 0 and req_i=16'h0180, the next grant is index 7 in fixed mode.
